// File: rtl/wire_change_monitor.sv
// Bus change monitor: logs {new, previous, timestamp} on each change of sample_in into a FWFT FIFO.
// Optional 2-flop input synchronizer enabled by defining WIRE_CHANGE_MONITOR_SYNC_EN.
module wire_change_monitor #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         sample_in,
  input  logic                     enable,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [WIDTH-1:0]         ev_data,
  output logic [WIDTH-1:0]         ev_prev,
  output logic [TS_W-1:0]          ev_time,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] prev;
    logic [TS_W-1:0]  ts;
  } ev_t;

  logic [WIDTH-1:0] s_q, s_d, prev_q, prev_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  ev_t              mem_q [DEPTH];
  ev_t              mem_d [DEPTH];
  ev_t              head;
  logic             chg, full, pop, push;

`ifdef WIRE_CHANGE_MONITOR_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = sample_in;
    sync2_d = sync1_q;
    s_d     = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
`else
  always_comb s_d = sample_in;
`endif

  assign chg  = enable && (s_q != prev_q);
  assign full = (cnt_q == FULL_CNT);
  assign pop  = ev_valid && ev_ready;
  // A full FIFO still accepts a new event when the head leaves on the same edge.
  assign push = chg && (!full || pop);

  always_comb begin
    prev_d = s_q;
    ts_d   = ts_q + TS_W'(1);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    mem_d  = mem_q;
    ovf_d  = ovf_q;
    if (push) begin
      mem_d[wptr_q] = '{data: s_q, prev: prev_q, ts: ts_q};
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
    if (chg && !push)        ovf_d = 1'b1;
    else if (clear_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      prev_q <= '0;
      ts_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      mem_q  <= '{default: '0};
    end else begin
      s_q    <= s_d;
      prev_q <= prev_d;
      ts_q   <= ts_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      mem_q  <= mem_d;
    end
  end

  // Head fields are forced to zero while empty so stale RAM contents never show.
  always_comb begin
    head = mem_q[rptr_q];
    if (cnt_q == '0) head = '0;
  end

  assign ev_valid = (cnt_q != '0);
  assign ev_data  = head.data;
  assign ev_prev  = head.prev;
  assign ev_time  = head.ts;
  assign count    = cnt_q;
  assign overflow = ovf_q;
endmodule

// File: doc/wire_change_monitor.md
Name: wire_change_monitor

Overview:
- Observing end of a driven signal set: samples a WIDTH-bit input bus every clock and detects value changes.
- Logs each change as an event {new value, previous value, timestamp} into a DEPTH-entry FIFO.
- A consumer drains the FIFO over a valid/ready interface.
- Used as an on-chip monitor for testbenches and debug of driven nets.

Parameters:
- WIDTH, 4, width of monitored bus.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- TS_W, 16, timestamp counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- sample_in  input  WIDTH  monitored bus.
- enable  input  1  1 = log changes; 0 = track but do not log.
- ev_valid  output  1  FIFO head entry available.
- ev_ready  input  1  consumer accepts head entry when ev_valid && ev_ready.
- ev_data  output  WIDTH  new value of head event.
- ev_prev  output  WIDTH  value before the change.
- ev_time  output  TS_W  timestamp of head event.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky: an event was dropped.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release): s_q=0, prev_q=0, ts=0, FIFO empty, count=0, ev_valid=0, overflow=0. ev_data, ev_prev and ev_time = 0 while empty.
- Pipeline:
  - s_q <= sample_in every cycle.
  - prev_q <= s_q every cycle, regardless of enable.
- Change detect is combinational: chg = enable && (s_q != prev_q).
- Timestamp: ts increments by 1 every clock after reset and wraps 2^TS_W-1 -> 0.
- Push: on a clock edge where chg=1, write {s_q, prev_q, ts} (current ts before increment).
- Latency: sample_in changes before edge N -> s_q updates at N -> entry written at edge N+1 -> ev_valid high after N+1. Minimum 2 clocks from input to ev_valid.
- Back-to-back changes on consecutive cycles each produce one event.
- A value held for k cycles produces exactly one event.
- Pop: ev_valid && ev_ready at an edge removes the head. The next entry, if any, is presented the following cycle with no bubble.
- FIFO output is first-word-fall-through from registers. ev_* reflect the head entry and stay stable while ev_valid && !ev_ready.
- Full (count==DEPTH):
  - Push with simultaneous pop: accepted, count unchanged.
  - Push without pop: event dropped, overflow<=1, prev_q still updates.
- Empty: pop ignored (ev_valid=0). Simultaneous push and empty: ev_valid rises next cycle.
- Pointers: log2(DEPTH) bits, wrap naturally. count = writes - reads, range 0..DEPTH.
- overflow: a set condition and clear_overflow in the same cycle leave overflow=1 (set wins).
- Re-enable: enable 0->1 does not emit stale events, because prev_q tracked during disable.
- Reset mid-operation: all state clears immediately and asynchronously. Pending events are lost. ev_valid drops to 0 without handshake.
- X/Z on sample_in is not filtered. Users drive known values.

Optional Feature:
- Macro WIRE_CHANGE_MONITOR_SYNC_EN.
- When defined:
  - Two extra flops (sync1, sync2, reset 0) are inserted before s_q as a metastability synchronizer for asynchronous sample_in.
  - Input-to-ev_valid latency becomes 4 clocks.
  - Timestamps refer to detection time, i.e. 2 cycles later than undefined mode.
- When undefined: no synchronizer, latency 2 clocks. sample_in must be synchronous to clk.

Test Plan:
- Reset values: rst_n=0 with sample_in=4'h5 -> ev_valid=0, count=0, overflow=0. Release reset, enable=1 -> exactly one event ev_prev=0, ev_data=5, ev_valid high 2 clocks after the first edge.
- Hold and change: hold 4'h3 for 10 cycles, then 4'hA, ev_ready=1 -> events (0->3) then (3->A). ev_time difference = 10. No further events.
- Disable: enable=0; toggle 1,2,3; enable=1; hold 3 -> no events logged, count=0.
- Overflow: ev_ready=0, 9 distinct consecutive values, DEPTH=8 -> count=8, overflow=1. Drain yields the first 8 events in order. clear_overflow -> overflow=0.
- Full with simultaneous pop: count=8, push and pop same cycle -> count stays 8, overflow stays 0, no entry lost.
- Async reset mid-drain: count=5, assert rst_n between edges -> ev_valid=0 and count=0 immediately. After release, ts restarts from 0.
